sseg_scan_hex: RTL and testbench

- Time-multiplexed N-digit hex seven-segment driver: latches a packed hex word, scans one digit per slot, drives shared active-low segment bus and per-digit active-low anodes.
- Generalises the single-digit hex decoder: parametrised digit count and scan rate, per-digit enable/decimal point, tear-free frame-aligned update, anti-ghosting dead time.
- Sits between user logic and board display pins.

---
 rtl/sseg_scan_hex.sv | 185 ++++++++++++++++++
 tb/tb_sseg_scan_hex.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_hex.sv
// ============================================================================
// Module   : sseg_scan_hex
// Brief    : Time-multiplexed N-digit hex seven-segment driver. Captures a
//            packed hex word into a pending buffer, moves it to the display
//            buffer only at a frame boundary, and scans one digit per slot
//            with a dead time between slots to suppress ghosting.
//            Optional leading-zero blanking is enabled by defining the
//            macro SSEG_LZB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sseg_scan_hex #(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [4*N_DIGITS-1:0] i_hex,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic [N_DIGITS-1:0]   i_digit_en,
  input  logic                  i_load,
  output logic [N_DIGITS-1:0]   o_an_n,
  output logic [7:0]            o_sseg_n,
  output logic                  o_frame_tick,
  output logic                  o_pending
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] C_IDX_MAX = IDX_W'(N_DIGITS - 1);
  localparam logic [31:0]      C_DEAD    = 32'(DEAD_CYC);

  // Hex nibble to active-low a..g pattern (bit6 = a, bit0 = g).
  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]      slot_q, slot_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] pend_hex_q, pend_hex_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]   pend_en_q, pend_en_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [4*N_DIGITS-1:0] disp_hex_q, disp_hex_d;
  logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [N_DIGITS-1:0]   disp_en_q, disp_en_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [7:0]            sseg_q, sseg_d;

  logic                  slot_wrap;
  logic                  frame_end;
  logic                  dead;
  logic [3:0]            hex_sel;
  logic [N_DIGITS-1:0]   lz_blank;

  assign slot_wrap = (slot_q == C_CNT_MAX);
  assign frame_end = slot_wrap && (idx_q == C_IDX_MAX);
  assign dead      = ({{(32-CNT_W){1'b0}}, slot_q} < C_DEAD);

`ifdef SSEG_LZB_EN
  // Blank digit k>0 while it and every enabled digit above it read as a bare zero.
  always_comb begin : g_lzb
    logic lz_run;
    lz_run   = 1'b1;
    lz_blank = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      if (disp_en_q[k] && ((disp_hex_q[4*k +: 4] != 4'h0) || disp_dp_q[k])) begin
        lz_run = 1'b0;
      end
      lz_blank[k] = lz_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Slot counter and digit index advance; the index steps once per slot wrap.
  always_comb begin
    slot_d = slot_wrap ? '0 : slot_q + CNT_W'(1);
    idx_d  = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == C_IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Pending capture and frame-aligned transfer; a load in the transfer cycle
  // bypasses the pending buffer so the newest data lands on the display.
  always_comb begin
    pend_hex_d = pend_hex_q;
    pend_dp_d  = pend_dp_q;
    pend_en_d  = pend_en_q;
    pend_vld_d = pend_vld_q;
    disp_hex_d = disp_hex_q;
    disp_dp_d  = disp_dp_q;
    disp_en_d  = disp_en_q;
    if (i_load) begin
      pend_hex_d = i_hex;
      pend_dp_d  = i_dp;
      pend_en_d  = i_digit_en;
      pend_vld_d = 1'b1;
    end
    if (frame_end) begin
      pend_vld_d = 1'b0;
      if (i_load) begin
        disp_hex_d = i_hex;
        disp_dp_d  = i_dp;
        disp_en_d  = i_digit_en;
      end else if (pend_vld_q) begin
        disp_hex_d = pend_hex_q;
        disp_dp_d  = pend_dp_q;
        disp_en_d  = pend_en_q;
      end
    end
  end

  // Next anode/segment pattern for the current slot; dark during dead time.
  always_comb begin
    hex_sel = disp_hex_q[{idx_q, 2'b00} +: 4];
    an_d    = '1;
    sseg_d  = 8'hFF;
    if (!dead && disp_en_q[idx_q] && !lz_blank[idx_q]) begin
      an_d[idx_q] = 1'b0;
      sseg_d      = {seg_decode(hex_sel), ~disp_dp_q[idx_q]};
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_q     <= '0;
      idx_q      <= '0;
      pend_hex_q <= '0;
      pend_dp_q  <= '0;
      pend_en_q  <= '0;
      pend_vld_q <= 1'b0;
      disp_hex_q <= '0;
      disp_dp_q  <= '0;
      disp_en_q  <= '0;
      an_q       <= '1;
      sseg_q     <= 8'hFF;
    end else begin
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      pend_hex_q <= pend_hex_d;
      pend_dp_q  <= pend_dp_d;
      pend_en_q  <= pend_en_d;
      pend_vld_q <= pend_vld_d;
      disp_hex_q <= disp_hex_d;
      disp_dp_q  <= disp_dp_d;
      disp_en_q  <= disp_en_d;
      an_q       <= an_d;
      sseg_q     <= sseg_d;
    end
  end

  assign o_an_n       = an_q;
  assign o_sseg_n     = sseg_q;
  assign o_frame_tick = frame_end;
  assign o_pending    = pend_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_hex.sv
// ============================================================================
// Module   : tb_sseg_scan_hex
// Brief    : Directed bench for sseg_scan_hex (N_DIGITS=4, SCAN_DIV=8,
//            DEAD_CYC=2) using a vector table plus hand-written sequences.
//            Covers the SSEG_LZB_EN case when that macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sseg_scan_hex;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] hex;
  logic [3:0]  dp;
  logic [3:0]  en;
  logic        load;
  logic [3:0]  an_n;
  logic [7:0]  sseg_n;
  logic        tick;
  logic        pending;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [7:0]  seg [4];
    logic [3:0]  an  [4];
  } vec_t;

  vec_t vecs [4];

  sseg_scan_hex #(.N_DIGITS(4), .SCAN_DIV(8), .DEAD_CYC(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_hex        (hex),
    .i_dp         (dp),
    .i_digit_en   (en),
    .i_load       (load),
    .o_an_n       (an_n),
    .o_sseg_n     (sseg_n),
    .o_frame_tick (tick),
    .o_pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance until the frame tick is seen at a negedge, bounded.
  task automatic wait_tick();
    bit found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (tick) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL wait_tick: got no tick expected tick within 80 cycles");
    end
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] d, input logic [3:0] e);
    hex  = h;
    dp   = d;
    en   = e;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Frame right after a tick: negedge j reflects slot state j-2 of the new frame.
  task automatic check_frame(input int v);
    for (int j = 1; j <= 33; j++) begin
      int pos, d, s;
      step();
      if (j == 1)  chk("pending_clr", 32'(pending), 32'd0);
      if (j == 16) chk("tick_mid", 32'(tick), 32'd0);
      if (j == 32) chk("tick_end", 32'(tick), 32'd1);
      pos = j - 2;
      if (pos >= 0) begin
        d = pos / 8;
        s = pos % 8;
        if (s < 2) begin
          chk("dead_an", 32'(an_n), 32'hF);
          chk("dead_seg", 32'(sseg_n), 32'hFF);
        end else if (s == 4) begin
          chk("vec_an", 32'(an_n), 32'(vecs[v].an[d]));
          chk("vec_seg", 32'(sseg_n), 32'(vecs[v].seg[d]));
        end
      end
    end
  endtask

  initial begin
    int first_t, second_t, n;

    vecs[0] = '{hex: 16'h1A2F, dp: 4'b0100, en: 4'hF,
                seg: '{8'h71, 8'h25, 8'h10, 8'h9F}, an: '{4'hE, 4'hD, 4'hB, 4'h7}};
    vecs[1] = '{hex: 16'h9C8E, dp: 4'b0000, en: 4'b0101,
                seg: '{8'h61, 8'hFF, 8'h63, 8'hFF}, an: '{4'hE, 4'hF, 4'hB, 4'hF}};
    vecs[2] = '{hex: 16'h7654, dp: 4'b1111, en: 4'hF,
                seg: '{8'h98, 8'h48, 8'h40, 8'h1E}, an: '{4'hE, 4'hD, 4'hB, 4'h7}};
    vecs[3] = '{hex: 16'hDB30, dp: 4'b1010, en: 4'hF,
                seg: '{8'h03, 8'h0C, 8'hC1, 8'h84}, an: '{4'hE, 4'hD, 4'hB, 4'h7}};

    rst_n = 1'b0;
    hex   = '0;
    dp    = '0;
    en    = '0;
    load  = 1'b0;

    // Reset values.
    #23;
    chk("rst_an", 32'(an_n), 32'hF);
    chk("rst_seg", 32'(sseg_n), 32'hFF);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);

    // No load: dark display, tick every 32 cycles starting 31 edges after release.
    @(negedge clk);
    rst_n    = 1'b1;
    first_t  = -1;
    second_t = -1;
    for (int i = 1; i <= 64; i++) begin
      step();
      chk("idle_dark", {an_n, sseg_n}, {4'hF, 8'hFF});
      if (tick) begin
        if (first_t < 0) first_t = i;
        else if (second_t < 0) second_t = i;
      end
    end
    chk("first_tick", 32'(first_t), 32'd31);
    chk("tick_period", 32'(second_t - first_t), 32'd32);

    // Table vectors: load, pending until tick, then a full frame of checks.
    for (int v = 0; v < 4; v++) begin
      do_load(vecs[v].hex, vecs[v].dp, vecs[v].en);
      chk("pend_set", 32'(pending), 32'd1);
      wait_tick();
      check_frame(v);
    end

    // Two loads in one frame: display untouched until the tick, last load wins.
    do_load(16'h8888, 4'h0, 4'hF);
    step();
    step();
    do_load(16'h2222, 4'h0, 4'hF);
    chk("pend_two", 32'(pending), 32'd1);
    wait_tick();
    chk("old_seg", 32'(sseg_n), 32'h84);
    chk("old_an", 32'(an_n), 32'h7);
    for (int j = 0; j < 4; j++) step();
    chk("last_wins_seg", 32'(sseg_n), 32'h25);
    chk("last_wins_an", 32'(an_n), 32'hE);

    // Load coincident with the tick cycle goes straight to the display.
    wait_tick();
    hex  = 16'h3335;
    dp   = 4'h0;
    en   = 4'hF;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("direct_pend", 32'(pending), 32'd0);
    for (int j = 0; j < 3; j++) step();
    chk("direct_seg", 32'(sseg_n), 32'h49);
    chk("direct_an", 32'(an_n), 32'hE);

    // Mid-slot asynchronous reset, then scan restarts at digit 0 slot 0.
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an", 32'(an_n), 32'hF);
    chk("arst_seg", 32'(sseg_n), 32'hFF);
    chk("arst_pend", 32'(pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hex   = vecs[0].hex;
    dp    = vecs[0].dp;
    en    = vecs[0].en;
    load  = 1'b1;
    n     = 0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      n = i;
      @(negedge clk);
      load = 1'b0;
      if (tick) break;
    end
    chk("restart_tick", 32'(n), 32'd31);
    check_frame(0);

`ifdef SSEG_LZB_EN
    // Leading-zero blanking: 0070 shows only digits 1 and 0.
    do_load(16'h0070, 4'h0, 4'hF);
    wait_tick();
    for (int j = 1; j <= 32; j++) begin
      step();
      if (j == 6)  chk("lzb_d0", {an_n, sseg_n}, {4'hE, 8'h03});
      if (j == 14) chk("lzb_d1", {an_n, sseg_n}, {4'hD, 8'h1F});
      if (j == 22) chk("lzb_d2", {an_n, sseg_n}, {4'hF, 8'hFF});
      if (j == 30) chk("lzb_d3", {an_n, sseg_n}, {4'hF, 8'hFF});
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
